// File: rtl/wash_job_scheduler_if.sv
// Station/washer bundle for the wash job scheduler.
// The scheduler takes the slave view; the stations plus washer take the master view.
interface wash_job_scheduler_if #(
    parameter int NREQ   = 4,
    parameter int QDEPTH = 4
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(QDEPTH) + 1;

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] req_double;
    logic [NREQ-1:0] req_ack;
    logic            coin_in;
    logic            double_wash;
    logic            timer_stop;
    logic            wash_done;
    logic [NREQ-1:0] job_done;
    logic [IDW-1:0]  active_id;
    logic            busy;
    logic            paused;
    logic [CW-1:0]   queue_count;
    logic            fault;

    modport slave (
        input  req, req_double, timer_stop, wash_done,
        output req_ack, coin_in, double_wash, job_done, active_id,
               busy, paused, queue_count, fault
    );

    modport master (
        output req, req_double, timer_stop, wash_done,
        input  req_ack, coin_in, double_wash, job_done, active_id,
               busy, paused, queue_count, fault
    );
endinterface

// File: rtl/wash_job_scheduler.sv
// Wash job scheduler: round-robin admission of station requests into a small
// FIFO, then one-at-a-time dispatch to the washer (coin pulse, held double-wash
// option, wait for wash_done).
// Optional watchdog: define WASH_SCHED_WDOG_EN to abort jobs that run for
// WDOG_CYCLES unpaused cycles without wash_done (sets the sticky fault flag).
module wash_job_scheduler #(
    parameter int NREQ        = 4,
    parameter int QDEPTH      = 4,
    parameter int WDOG_CYCLES = 1000
) (
    input logic                  clk,
    input logic                  reset,
    wash_job_scheduler_if.slave  bus
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(QDEPTH) + 1;
    localparam int PW  = $clog2(QDEPTH);
    localparam int SW  = IDW + 1;
    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN} state_t;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           dbl;
    } entry_t;

    state_t          r_state;
    state_t          w_state_nxt;
    entry_t          r_fifo [QDEPTH];
    entry_t          w_head;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [NREQ-1:0] r_pending;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  r_active_id;
    logic [NREQ-1:0] r_req_ack;
    logic [NREQ-1:0] r_job_done;
    logic            r_coin_in;
    logic            r_double_wash;
    logic            r_busy;

    logic [NREQ-1:0] w_eligible;
    logic [SW-1:0]   w_idx;
    logic            w_grant_vld;
    logic [IDW-1:0]  w_grant_id;
    logic            w_push;
    logic            w_pop;
    logic            w_done;
    logic            w_abort;
    logic            w_wdog_hit;
    logic [NREQ-1:0] w_active_oh;
    logic [NREQ-1:0] w_pend_set;
    logic [NREQ-1:0] w_pend_clr;

    assign w_eligible  = bus.req & ~r_pending;
    assign w_head      = r_fifo[r_rd_ptr];
    assign w_active_oh = ONE << r_active_id;
    assign w_push      = w_grant_vld;
    assign w_pend_set  = w_grant_vld ? (ONE << w_grant_id) : '0;
    assign w_pend_clr  = (w_done || w_abort) ? w_active_oh : '0;

    // Round-robin grant: first eligible station at or after rr_ptr, blocked when full.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_grant_vld = 1'b0;
        w_grant_id  = '0;
        w_idx       = '0;
        // Scan from farthest to nearest offset so the nearest eligible station wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_rr_ptr} + SW'(k);
            if (w_idx >= SW'(NREQ)) begin
                w_idx = w_idx - SW'(NREQ);
            end
            if (w_eligible[w_idx[IDW-1:0]]) begin
                w_grant_vld = 1'b1;
                w_grant_id  = w_idx[IDW-1:0];
            end
        end
        if (r_count == CW'(QDEPTH)) begin
            w_grant_vld = 1'b0;
        end
    end

    // Dispatcher next-state and job events.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0 && !bus.timer_stop) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: w_state_nxt = S_RUN;
            S_RUN: begin
                if (bus.wash_done) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_wdog_hit) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Dispatcher state register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // FIFO storage; only the pointers and count need a reset.
    always_ff @(posedge clk) begin
        // NOTE: the entry array is not reset; stale entries are unreachable while the count is zero.
        if (w_push) begin
            r_fifo[r_wr_ptr] <= '{id: w_grant_id, dbl: bus.req_double[w_grant_id]};
        end
    end

    // FIFO pointers, occupancy, pending set and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_pending <= '0;
            r_rr_ptr  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_pending <= (r_pending & ~w_pend_clr) | w_pend_set;
            if (w_grant_vld) begin
                r_rr_ptr <= (w_grant_id == IDW'(NREQ - 1)) ? '0 : w_grant_id + IDW'(1);
            end
        end
    end

    // Registered handshake and job outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req_ack     <= '0;
            r_job_done    <= '0;
            r_coin_in     <= 1'b0;
            r_double_wash <= 1'b0;
            r_busy        <= 1'b0;
            r_active_id   <= '0;
        end else begin
            r_req_ack  <= w_pend_set;
            r_job_done <= w_done ? w_active_oh : '0;
            r_coin_in  <= w_pop;
            r_busy     <= (w_state_nxt != S_IDLE);
            if (w_pop) begin
                r_active_id   <= w_head.id;
                r_double_wash <= w_head.dbl;
            end else if (w_done || w_abort) begin
                r_double_wash <= 1'b0;
            end
        end
    end

`ifdef WASH_SCHED_WDOG_EN
    logic [15:0] r_wdog;
    logic        r_fault;

    assign w_wdog_hit = (r_state == S_RUN) && !bus.timer_stop &&
                        (r_wdog == 16'(WDOG_CYCLES - 1));

    // Watchdog: cleared on launch, counts unpaused run cycles; abort latches fault.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wdog  <= '0;
            r_fault <= 1'b0;
        end else begin
            if (r_state == S_LAUNCH)                    r_wdog <= '0;
            else if (r_state == S_RUN && !bus.timer_stop) r_wdog <= r_wdog + 16'd1;
            if (w_abort) r_fault <= 1'b1;
        end
    end

    assign bus.fault = r_fault;
`else
    assign w_wdog_hit = 1'b0;
    assign bus.fault  = 1'b0;
`endif

    assign bus.req_ack     = r_req_ack;
    assign bus.job_done    = r_job_done;
    assign bus.coin_in     = r_coin_in;
    assign bus.double_wash = r_double_wash;
    assign bus.active_id   = r_active_id;
    assign bus.busy        = r_busy;
    assign bus.paused      = r_busy & bus.timer_stop;
    assign bus.queue_count = r_count;
endmodule

// File: tb/tb_wash_job_scheduler.sv
// Self-checking bench for wash_job_scheduler: directed scenarios plus a
// randomized run against a queue-based reference model of admission/dispatch.
module tb_wash_job_scheduler;
    localparam int NREQ   = 8;
    localparam int QDEPTH = 4;
    localparam int WDOG   = 20;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    wash_job_scheduler_if #(.NREQ(NREQ), .QDEPTH(QDEPTH)) bus ();

    wash_job_scheduler #(.NREQ(NREQ), .QDEPTH(QDEPTH), .WDOG_CYCLES(WDOG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [26:0] all_outs;
    assign all_outs = {bus.req_ack, bus.job_done, bus.coin_in, bus.double_wash, bus.busy,
                       bus.paused, bus.active_id, bus.queue_count, bus.fault};

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NREQ-1:0] bit_of(int s);
        return NREQ'(1) << s;
    endfunction

    task automatic apply_reset();
        bus.req        = '0;
        bus.req_double = '0;
        bus.timer_stop = 1'b0;
        bus.wash_done  = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Wait (bounded) until the washer job is in RUN: busy with no coin pulse.
    task automatic wait_run(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (bus.busy && !bus.coin_in) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        apply_reset();
        reset = 1'b1;
        #2;
        checks++; if (all_outs !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", all_outs); end
        tick();
        reset = 1'b0;
        tick();
        checks++; if (all_outs !== '0) begin failures++; $display("FAIL reset_release_idle got=%h exp=0", all_outs); end
    endtask

    task automatic test_single();
        apply_reset();
        bus.req        = 8'b0000_0100;
        bus.req_double = 8'b0000_0100;
        tick();
        checks++; if (bus.req_ack !== 8'b0000_0100) begin failures++; $display("FAIL single_ack got=%b exp=%b", bus.req_ack, 8'b0000_0100); end
        checks++; if (bus.coin_in !== 1'b0) begin failures++; $display("FAIL single_coin_early got=%b exp=0", bus.coin_in); end
        bus.req = '0;
        bus.req_double = '0;
        tick();
        checks++; if (bus.req_ack !== '0) begin failures++; $display("FAIL single_ack_width got=%b exp=0", bus.req_ack); end
        checks++; if (bus.coin_in !== 1'b1) begin failures++; $display("FAIL single_coin got=%b exp=1", bus.coin_in); end
        checks++; if (bus.double_wash !== 1'b1) begin failures++; $display("FAIL single_double got=%b exp=1", bus.double_wash); end
        checks++; if (bus.active_id !== 3'd2) begin failures++; $display("FAIL single_active_id got=%0d exp=2", bus.active_id); end
        tick();
        checks++; if ({bus.coin_in, bus.busy} !== 2'b01) begin failures++; $display("FAIL single_run got coin/busy=%b exp=01", {bus.coin_in, bus.busy}); end
        bus.wash_done = 1'b1;
        tick();
        bus.wash_done = 1'b0;
        checks++; if (bus.job_done !== 8'b0000_0100) begin failures++; $display("FAIL single_job_done got=%b exp=%b", bus.job_done, 8'b0000_0100); end
        checks++; if ({bus.busy, bus.double_wash} !== 2'b00) begin failures++; $display("FAIL single_end got busy/double=%b exp=00", {bus.busy, bus.double_wash}); end
        tick();
        checks++; if (bus.job_done !== '0) begin failures++; $display("FAIL single_job_done_width got=%b exp=0", bus.job_done); end
    endtask

    task automatic test_round_robin();
        bit ok;
        apply_reset();
        bus.req = 8'h0F;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (bus.req_ack !== bit_of(k)) begin failures++; $display("FAIL rr_ack%0d got=%b exp=%b", k, bus.req_ack, bit_of(k)); end
            bus.req = bus.req & ~bus.req_ack;
        end
        checks++; if (bus.queue_count !== 3'd3) begin failures++; $display("FAIL rr_queue_count got=%0d exp=3", bus.queue_count); end
        for (int k = 0; k < 4; k++) begin
            wait_run(ok);
            checks++; if (!ok) begin failures++; $display("FAIL rr_wait_run%0d got=timeout exp=run", k); end
            checks++; if (bus.active_id !== 3'(k)) begin failures++; $display("FAIL rr_order%0d got=%0d exp=%0d", k, bus.active_id, k); end
            bus.wash_done = 1'b1;
            tick();
            bus.wash_done = 1'b0;
            checks++; if (bus.job_done !== bit_of(k)) begin failures++; $display("FAIL rr_job_done%0d got=%b exp=%b", k, bus.job_done, bit_of(k)); end
            if (k < 3) begin
                tick();
                checks++; if (bus.coin_in !== 1'b1) begin failures++; $display("FAIL rr_relaunch%0d got=%b exp=1", k, bus.coin_in); end
            end
        end
    endtask

    task automatic test_full_fifo();
        apply_reset();
        bus.req = 8'hFF;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (bus.req_ack !== bit_of(k)) begin failures++; $display("FAIL full_ack%0d got=%b exp=%b", k, bus.req_ack, bit_of(k)); end
            bus.req = bus.req & ~bus.req_ack;
        end
        for (int n = 0; n < 5; n++) begin
            tick();
            checks++; if (bus.req_ack !== '0) begin failures++; $display("FAIL full_blocked got=%b exp=0", bus.req_ack); end
            checks++; if (bus.queue_count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", bus.queue_count); end
        end
        bus.wash_done = 1'b1;
        tick();
        bus.wash_done = 1'b0;
        checks++; if (bus.job_done !== bit_of(0)) begin failures++; $display("FAIL full_job_done got=%b exp=%b", bus.job_done, bit_of(0)); end
        checks++; if (bus.req_ack !== '0) begin failures++; $display("FAIL full_ack_at_done got=%b exp=0", bus.req_ack); end
        tick();
        checks++; if (bus.coin_in !== 1'b1) begin failures++; $display("FAIL full_pop got=%b exp=1", bus.coin_in); end
        checks++; if (bus.req_ack !== '0) begin failures++; $display("FAIL full_push_on_pop got=%b exp=0", bus.req_ack); end
        checks++; if (bus.queue_count !== 3'd3) begin failures++; $display("FAIL full_count_after_pop got=%0d exp=3", bus.queue_count); end
        tick();
        checks++; if (bus.req_ack !== bit_of(5)) begin failures++; $display("FAIL full_next_ack got=%b exp=%b", bus.req_ack, bit_of(5)); end
        checks++; if (bus.queue_count !== 3'd4) begin failures++; $display("FAIL full_refill got=%0d exp=4", bus.queue_count); end
    endtask

    task automatic test_duplicate_pause();
        apply_reset();
        bus.req = bit_of(1);
        tick();
        checks++; if (bus.req_ack !== bit_of(1)) begin failures++; $display("FAIL dup_first_ack got=%b exp=%b", bus.req_ack, bit_of(1)); end
        for (int n = 0; n < 4; n++) begin
            tick();
            checks++; if (bus.req_ack !== '0) begin failures++; $display("FAIL dup_no_ack got=%b exp=0", bus.req_ack); end
        end
        bus.timer_stop = 1'b1;
        for (int n = 0; n < 50; n++) begin
            tick();
            checks++; if ({bus.paused, bus.busy, bus.fault} !== 3'b110) begin failures++; $display("FAIL pause_state got paused/busy/fault=%b exp=110", {bus.paused, bus.busy, bus.fault}); end
            checks++; if (bus.job_done !== '0) begin failures++; $display("FAIL pause_job_done got=%b exp=0", bus.job_done); end
        end
        bus.timer_stop = 1'b0;
        bus.req = '0;
        tick();
        checks++; if (bus.paused !== 1'b0) begin failures++; $display("FAIL pause_release got=%b exp=0", bus.paused); end
        bus.wash_done = 1'b1;
        tick();
        bus.wash_done = 1'b0;
        checks++; if (bus.job_done !== bit_of(1)) begin failures++; $display("FAIL pause_job_done_end got=%b exp=%b", bus.job_done, bit_of(1)); end
        checks++; if (bus.fault !== 1'b0) begin failures++; $display("FAIL pause_fault got=%b exp=0", bus.fault); end
    endtask

`ifdef WASH_SCHED_WDOG_EN
    task automatic test_watchdog();
        bit ok;
        apply_reset();
        bus.req = bit_of(0) | bit_of(3);
        tick();
        bus.req = bus.req & ~bus.req_ack;
        tick();
        bus.req = bus.req & ~bus.req_ack;
        tick();
        for (int n = 1; n < WDOG; n++) begin
            tick();
            checks++; if ({bus.fault, bus.busy} !== 2'b01) begin failures++; $display("FAIL wdog_early%0d got fault/busy=%b exp=01", n, {bus.fault, bus.busy}); end
        end
        tick();
        checks++; if ({bus.fault, bus.busy} !== 2'b10) begin failures++; $display("FAIL wdog_abort got fault/busy=%b exp=10", {bus.fault, bus.busy}); end
        checks++; if (bus.job_done !== '0) begin failures++; $display("FAIL wdog_no_job_done got=%b exp=0", bus.job_done); end
        tick();
        checks++; if ({bus.coin_in, bus.active_id} !== {1'b1, 3'd3}) begin failures++; $display("FAIL wdog_next_launch got coin/id=%b/%0d exp=1/3", bus.coin_in, bus.active_id); end
        wait_run(ok);
        bus.wash_done = 1'b1;
        tick();
        bus.wash_done = 1'b0;
        checks++; if (bus.job_done !== bit_of(3)) begin failures++; $display("FAIL wdog_next_done got=%b exp=%b", bus.job_done, bit_of(3)); end
        checks++; if (bus.fault !== 1'b1) begin failures++; $display("FAIL wdog_sticky got=%b exp=1", bus.fault); end
    endtask
`else
    task automatic test_no_watchdog();
        apply_reset();
        bus.req = bit_of(0);
        tick();
        bus.req = '0;
        for (int n = 0; n < 3 * WDOG; n++) begin
            tick();
            checks++; if ({bus.fault, bus.busy} !== 2'b01) begin failures++; $display("FAIL nowdog_wait got fault/busy=%b exp=01", {bus.fault, bus.busy}); end
        end
        bus.wash_done = 1'b1;
        tick();
        bus.wash_done = 1'b0;
        checks++; if (bus.job_done !== bit_of(0)) begin failures++; $display("FAIL nowdog_done got=%b exp=%b", bus.job_done, bit_of(0)); end
    endtask
`endif

    task automatic test_reset_mid_run();
        apply_reset();
        bus.req        = 8'b0000_0111;
        bus.req_double = 8'b0000_0001;
        for (int k = 0; k < 3; k++) begin
            tick();
            bus.req = bus.req & ~bus.req_ack;
        end
        checks++; if ({bus.busy, bus.double_wash, bus.queue_count} !== {2'b11, 3'd2}) begin failures++; $display("FAIL midrun_setup got busy/dbl/count=%b/%b/%0d exp=1/1/2", bus.busy, bus.double_wash, bus.queue_count); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (all_outs !== '0) begin failures++; $display("FAIL midrun_reset_outputs got=%h exp=0", all_outs); end
        bus.req_double = '0;
        tick();
        reset = 1'b0;
        for (int n = 0; n < 8; n++) begin
            tick();
            checks++; if ({bus.coin_in, bus.busy} !== 2'b00) begin failures++; $display("FAIL midrun_quiet got coin/busy=%b exp=00", {bus.coin_in, bus.busy}); end
        end
        bus.req = bit_of(5);
        tick();
        bus.req = '0;
        checks++; if (bus.req_ack !== bit_of(5)) begin failures++; $display("FAIL midrun_new_ack got=%b exp=%b", bus.req_ack, bit_of(5)); end
        tick();
        checks++; if ({bus.coin_in, bus.active_id} !== {1'b1, 3'd5}) begin failures++; $display("FAIL midrun_new_launch got coin/id=%b/%0d exp=1/5", bus.coin_in, bus.active_id); end
    endtask

    // Random traffic against a transaction model: a queue of admitted jobs,
    // a pending set, the round-robin pointer and an idle/launch/run phase.
    task automatic test_random();
        int              q_id[$];
        bit              q_dbl[$];
        logic [NREQ-1:0] pend_m;
        int              rr_m, phase_m, act_m, grant, run_age, target;
        bit              dbl_m, e_coin;
        logic [NREQ-1:0] e_ack, e_done;
        apply_reset();
        pend_m = '0; rr_m = 0; phase_m = 0; act_m = 0; dbl_m = 1'b0;
        run_age = 0; target = 1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            grant = -1;
            if (q_id.size() < QDEPTH) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (grant < 0 && bus.req[(rr_m + k) % NREQ] && !pend_m[(rr_m + k) % NREQ]) grant = (rr_m + k) % NREQ;
                end
            end
            e_coin = 1'b0;
            e_done = '0;
            if (phase_m == 0) begin
                if (q_id.size() > 0 && !bus.timer_stop) begin
                    act_m   = q_id.pop_front();
                    dbl_m   = q_dbl.pop_front();
                    phase_m = 1;
                    e_coin  = 1'b1;
                    run_age = 0;
                    target  = $urandom_range(1, 8);
                end
            end else if (phase_m == 1) begin
                phase_m = 2;
            end else if (bus.wash_done) begin
                e_done = bit_of(act_m);
                pend_m[act_m] = 1'b0;
                dbl_m   = 1'b0;
                phase_m = 0;
            end
            e_ack = '0;
            if (grant >= 0) begin
                q_id.push_back(grant);
                q_dbl.push_back(bus.req_double[grant]);
                pend_m[grant] = 1'b1;
                rr_m  = (grant + 1) % NREQ;
                e_ack = bit_of(grant);
            end
            tick();
            checks++; if (bus.req_ack !== e_ack) begin failures++; $display("FAIL rnd_ack cyc=%0d got=%b exp=%b", cyc, bus.req_ack, e_ack); end
            checks++; if (bus.job_done !== e_done) begin failures++; $display("FAIL rnd_job_done cyc=%0d got=%b exp=%b", cyc, bus.job_done, e_done); end
            checks++; if (bus.coin_in !== e_coin) begin failures++; $display("FAIL rnd_coin cyc=%0d got=%b exp=%b", cyc, bus.coin_in, e_coin); end
            checks++; if (bus.busy !== (phase_m != 0)) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, bus.busy, phase_m != 0); end
            checks++; if (bus.paused !== ((phase_m != 0) && bus.timer_stop)) begin failures++; $display("FAIL rnd_paused cyc=%0d got=%b", cyc, bus.paused); end
            checks++; if (bus.double_wash !== dbl_m) begin failures++; $display("FAIL rnd_double cyc=%0d got=%b exp=%b", cyc, bus.double_wash, dbl_m); end
            checks++; if (bus.active_id !== 3'(act_m)) begin failures++; $display("FAIL rnd_active_id cyc=%0d got=%0d exp=%0d", cyc, bus.active_id, act_m); end
            checks++; if (bus.queue_count !== 3'(q_id.size())) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, bus.queue_count, q_id.size()); end
            checks++; if (bus.fault !== 1'b0) begin failures++; $display("FAIL rnd_fault cyc=%0d got=%b exp=0", cyc, bus.fault); end
            bus.req = bus.req & ~bus.req_ack;
            for (int s = 0; s < NREQ; s++) begin
                if (!bus.req[s] && $urandom_range(0, 7) == 0) bus.req[s] = 1'b1;
            end
            bus.req_double = NREQ'($urandom);
            bus.timer_stop = ($urandom_range(0, 9) == 0);
            if (phase_m == 2) run_age++;
            bus.wash_done = (phase_m == 2 && run_age >= target) || ($urandom_range(0, 29) == 0);
        end
        bus.req = '0;
        bus.wash_done = 1'b0;
        bus.timer_stop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full_fifo();
        test_duplicate_pause();
`ifdef WASH_SCHED_WDOG_EN
        test_watchdog();
`else
        test_no_watchdog();
`endif
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
